// File: rtl/quantum_scheduler.sv
// Round-robin time-slice controller: owns the per-process PC base offset, counts retired
// instructions against a fixed quantum and sequences the context-switch handshake.
module quantum_scheduler #(
    parameter int NUM_PROC = 4,
    parameter int QUANTUM  = 32,
    parameter int STRIDE   = 550
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [NUM_PROC-1:0] Proc_Valid,
    input  logic                Instr_Retire,
    input  logic                Halt,
    input  logic [31:0]         PC_Current,
    input  logic                Switch_Ack,
    output logic [31:0]         Offset,
    output logic [2:0]          Active_Proc,
    output logic                Quantum_End,
    output logic                Switch_Req,
    output logic                Load_PC,
    output logic [31:0]         Resume_PC,
    output logic                Kernel_Mode,
    output logic                All_Done
);

    localparam int PW    = $clog2(NUM_PROC);
    localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_SELECT,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PW-1:0]       act_q;
    logic [NUM_PROC-1:0] valid_q;
    logic [NUM_PROC-1:0] done_q;
    logic [NUM_PROC-1:0] runnable;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         pc_table [NUM_PROC];
    logic [PW-1:0]       cand;
    logic [PW-1:0]       sel_slot;
    logic                sel_found;
    logic                expire;
    logic [31:0]         run_offset;

    assign runnable    = valid_q & ~done_q;
    assign run_offset  = (32'(act_q) + 32'd1) * 32'(STRIDE);
    assign Active_Proc = 3'(act_q);

    // Walk downward so the nearest slot after the current one is the last match kept.
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = '0;
        cand      = '0;
        for (int i = NUM_PROC; i >= 1; i--) begin
            cand = PW'((int'(act_q) + i) % NUM_PROC);
            if (runnable[cand]) begin
                sel_found = 1'b1;
                sel_slot  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        expire  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (Start) state_d = S_SELECT;
            S_SELECT:       state_d = sel_found ? S_RESTORE : S_DONE;
            S_RESTORE:      state_d = S_RUN;
            S_RUN: begin
                // Halt takes priority over an expiring retire in the same cycle.
                if (Halt) begin
                    state_d = S_SAVE;
                end else if (Instr_Retire && cnt_q == CNT_LAST) begin
                    state_d = S_SAVE;
                    expire  = 1'b1;
                end
            end
            S_SAVE:         if (Switch_Ack) state_d = S_SELECT;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            act_q       <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < NUM_PROC; i++) pc_table[i] <= '0;
            Offset      <= '0;
            Quantum_End <= 1'b0;
            Switch_Req  <= 1'b0;
            Load_PC     <= 1'b0;
            Resume_PC   <= '0;
            Kernel_Mode <= 1'b1;
            All_Done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            Offset      <= (state_d == S_RUN) ? run_offset : 32'd0;
            Kernel_Mode <= (state_d != S_RUN);
            Switch_Req  <= (state_d == S_SAVE);
            All_Done    <= (state_d == S_DONE);
            Load_PC     <= (state_d == S_RESTORE);
            Quantum_End <= expire;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        valid_q <= Proc_Valid;
                        done_q  <= '0;
                        act_q   <= PW'(NUM_PROC - 1);
                        for (int i = 0; i < NUM_PROC; i++) pc_table[i] <= '0;
                    end
                end
                S_SELECT: begin
                    if (sel_found) begin
                        act_q     <= sel_slot;
                        Resume_PC <= pc_table[sel_slot];
                    end
                end
                S_RESTORE: cnt_q <= '0;
                S_RUN: begin
                    if (Halt) begin
                        done_q[act_q] <= 1'b1;
                    end else if (Instr_Retire) begin
                        if (cnt_q == CNT_LAST) begin
                            pc_table[act_q] <= PC_Current;
                            cnt_q           <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Round-robin time-slice controller for the multiprogrammed MIPS core. It owns the per-process program-memory base offset added to the PC, counts retired user instructions against a fixed quantum, and preempts on quantum expiry or process Halt. It also keeps a saved-PC table per process slot and sequences the context-switch handshake with the datapath. It sits between the kernel control logic (Start, process-valid mask) and the fetch/PC path (Offset, Load_PC, Resume_PC).

## Interface
- NUM_PROC, 4: number of user process slots (2..8)
- QUANTUM, 32: retired instructions per time slice (≥1)
- STRIDE, 550: program-memory words per process region; kernel occupies base 0
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  kernel pulse: latch Proc_Valid, begin scheduling
- Proc_Valid  in  NUM_PROC  slot i holds a loaded program
- Instr_Retire  in  1  one user instruction committed this cycle
- Halt  in  1  active process executed halt
- PC_Current  in  32  process-relative PC of next instruction, saved on preemption
- Switch_Ack  in  1  datapath finished register save/restore
- Offset  out  32  base added to PC; 0 in kernel mode
- Active_Proc  out  3  current slot index
- Quantum_End  out  1  one-cycle pulse on quantum expiry
- Switch_Req  out  1  context switch in progress; held until Switch_Ack
- Load_PC  out  1  one-cycle pulse: load Resume_PC into PC
- Resume_PC  out  32  saved PC of the slot being resumed
- Kernel_Mode  out  1  high whenever no user process is running
- All_Done  out  1  every valid slot has halted

## Operation
- States: IDLE, RUN, SAVE, SELECT, RESTORE, DONE.
- IDLE: Kernel_Mode=1, Offset=0. Start latches Proc_Valid into valid mask, clears done flags, zeroes PC table, Active_Proc=NUM_PROC-1 so first pick is slot 0 -> SELECT.
- SELECT (1 cycle): round-robin search from Active_Proc+1 (mod NUM_PROC) for first slot valid & !done. Found: Active_Proc<=slot -> RESTORE. None: -> DONE.
- RESTORE (1 cycle): Load_PC=1, Resume_PC=pc_table[Active_Proc]; quantum counter cleared -> RUN.
- RUN: Offset=(Active_Proc+1)*STRIDE, 32-bit unsigned, Kernel_Mode=0. Each Instr_Retire increments counter. Retire with counter==QUANTUM-1: pc_table[Active_Proc]<=PC_Current, Quantum_End pulse -> SAVE. Halt: done[Active_Proc]<=1, PC not saved -> SAVE.
- Halt and expiring retire in same cycle: Halt wins, no Quantum_End, no PC save.
- SAVE: Switch_Req=1, Offset=0, Kernel_Mode=1. Wait for Switch_Ack -> SELECT. Switch_Req deasserts on leaving SAVE.
- Only one runnable slot: expiry still passes SAVE/SELECT/RESTORE and reselects that slot with its saved PC.
- DONE: All_Done=1, Kernel_Mode=1, Offset=0. Start restarts exactly as from IDLE.
- Ignored inputs: Instr_Retire and Halt outside RUN; Start outside IDLE/DONE; Switch_Ack outside SAVE; Proc_Valid except at Start.

## Timing
- Reset (async, immediate): state=IDLE, Offset=0, Active_Proc=0, Quantum_End=0, Switch_Req=0, Load_PC=0, Resume_PC=0, Kernel_Mode=1, All_Done=0, counter=0, done flags and PC table cleared. Reset mid-switch abandons the handshake.
- All outputs registered, changing only at the Clock edge that enters the state.
- Start at edge k: SELECT at k+1, RESTORE at k+2 (Load_PC=1), RUN at k+3 (Offset valid).
- QUANTUM-th retire sampled at edge n: at n+1, Quantum_End=1, Switch_Req=1, Offset=0.
- Halt at edge n: at n+1, SAVE with Switch_Req=1.
- Switch_Ack at edge m: SELECT at m+1, RESTORE at m+2, RUN at m+3.
- Switch_Ack in the same cycle SAVE is entered is not sampled. SAVE lasts ≥1 cycle.

## Test plan
Use NUM_PROC=4, QUANTUM=4, STRIDE=550.

- Reset then Start with Proc_Valid=4'b0101 -> Load_PC pulse with Resume_PC=0, Active_Proc=0, Offset=550 three edges after Start.
- Four retires in slot 0 with PC_Current=16, then Switch_Ack -> Quantum_End one cycle, Active_Proc=2, Offset=1650. On return to slot 0, Resume_PC=16.
- Halt in slot 2 on the same cycle as the 4th retire -> no Quantum_End, slot 2 marked done, next RUN is slot 0. Halt in slot 0 -> DONE, All_Done=1, Offset=0.
- Proc_Valid=4'b1000 with repeated expiry -> always reselects slot 3 with Offset=2200, PC saved and restored each quantum.
- Switch_Ack withheld 10 cycles in SAVE -> Switch_Req held high, no state change. Retire/Halt pulses during SAVE have no effect.
- Reset_n low mid-RUN and mid-SAVE -> outputs take reset values immediately. Start with Proc_Valid=0 -> DONE with All_Done=1 two edges later.
